// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcodes, writeback-select encodings and hazard controller states.
// Imported by the hazard unit, its interface and the datapath.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        LW    = 6'h23,
        SW    = 6'h2b,
        HALT  = 6'h3f
    } opcode_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2,
        HALTED  = 2'd3
    } hazard_state_t;

    localparam logic [1:0] REGSEL_LOAD = 2'b11;

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == RTYPE) || (opcode == BEQ) || (opcode == BNE) || (opcode == SW);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of hazard-controller inputs and pipeline control outputs as seen by the datapath.
// The hu modport is the controller's view.
interface hazard_unit_if;
    import cpu_types_pkg::*;

    logic        ihit;
    logic        dhit;
    logic        dREN_me;
    logic        dWEN_me;
    logic [31:0] instru_de;
    logic        regWr_ex;
    logic [4:0]  regDst_ex;
    logic [1:0]  regSel_ex;
    logic        branchTaken_ex;
    logic        jump_de;
    logic        halt_wb;
    logic        pcEn;
    logic        en_fd;
    logic        en_de;
    logic        en_em;
    logic        en_mw;
    logic        flush_fd;
    logic        flush_de;
    logic        halt;

    modport hu (
        input  ihit, dhit, dREN_me, dWEN_me, instru_de, regWr_ex, regDst_ex,
               regSel_ex, branchTaken_ex, jump_de, halt_wb,
        output pcEn, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, halt
    );

endinterface

// File: rtl/stall_counter.sv
// Free-running 32-bit count of cycles in which the PC was held; wraps naturally.
module stall_counter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= 32'd0;
        end else if (inc) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, data-memory freeze, branch/jump squash,
// fetch miss and halt. Optional stall performance counter under HAZARD_PERF_CNT_EN.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int LOADUSE_BUBBLES = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dREN_me,
    input  logic        dWEN_me,
    input  logic [31:0] instru_de,
    input  logic        regWr_ex,
    input  logic [4:0]  regDst_ex,
    input  logic [1:0]  regSel_ex,
    input  logic        branchTaken_ex,
    input  logic        jump_de,
    input  logic        halt_wb,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    output logic        pcEn,
    output logic        en_fd,
    output logic        en_de,
    output logic        en_em,
    output logic        en_mw,
    output logic        flush_fd,
    output logic        flush_de,
    output logic        halt
);

    localparam int BW = (LOADUSE_BUBBLES > 2) ? $clog2(LOADUSE_BUBBLES) : 1;
    localparam logic [BW-1:0] BCNT_INIT = BW'(LOADUSE_BUBBLES - 1);

    hazard_state_t state_reg;
    logic [BW-1:0] bcnt_reg;

    logic [4:0] rs;
    logic [4:0] rt;
    logic       advance;
    logic       loaduse;
    logic       stall;
    logic       unused_bits;

    assign rs          = instru_de[25:21];
    assign rt          = instru_de[20:16];
    assign unused_bits = ^instru_de[15:0];
    assign advance     = !(dREN_me || dWEN_me) || dhit;
    assign loaduse     = regWr_ex && (regSel_ex == REGSEL_LOAD) && (regDst_ex != 5'd0) &&
                         ((regDst_ex == rs) || (uses_rt(instru_de[31:26]) && (regDst_ex == rt)));
    assign stall       = (state_reg == LDSTALL) || loaduse;

    always_comb begin
        pcEn     = 1'b0;
        en_fd    = 1'b0;
        en_de    = 1'b0;
        en_em    = 1'b0;
        en_mw    = 1'b0;
        flush_fd = 1'b0;
        flush_de = 1'b0;
        if (!nRST || state_reg == HALTED || !advance) begin
            // full freeze: everything already defaulted to 0
        end else if (branchTaken_ex) begin
            {pcEn, en_fd, en_de, en_em, en_mw} = 5'b11111;
            flush_fd = 1'b1;
            flush_de = 1'b1;
        end else if (stall) begin
            {en_de, en_em, en_mw} = 3'b111;
            flush_de = 1'b1;
        end else if (jump_de) begin
            {pcEn, en_fd, en_de, en_em, en_mw} = 5'b11111;
            flush_fd = 1'b1;
        end else if (!ihit) begin
            {en_fd, en_de, en_em, en_mw} = 4'b1111;
            flush_fd = 1'b1;
        end else begin
            {pcEn, en_fd, en_de, en_em, en_mw} = 5'b11111;
        end
    end

    // The detect cycle is the first bubble, so bcnt counts the bubbles still owed after it;
    // a data miss inside LDSTALL holds both state and count so no bubble is lost.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= RUN;
            bcnt_reg  <= '0;
            halt      <= 1'b0;
        end else if (state_reg != HALTED) begin
            if (halt_wb && advance) begin
                state_reg <= HALTED;
                halt      <= 1'b1;
            end else if (!advance) begin
                if (state_reg != LDSTALL) begin
                    state_reg <= MEMWAIT;
                end
            end else if (branchTaken_ex) begin
                state_reg <= RUN;
                bcnt_reg  <= '0;
            end else if (state_reg == LDSTALL) begin
                if (bcnt_reg <= BW'(1)) begin
                    state_reg <= RUN;
                    bcnt_reg  <= '0;
                end else begin
                    bcnt_reg <= bcnt_reg - BW'(1);
                end
            end else if (loaduse && LOADUSE_BUBBLES > 1) begin
                state_reg <= LDSTALL;
                bcnt_reg  <= BCNT_INIT;
            end else begin
                state_reg <= RUN;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    stall_counter u_stall_counter (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (!pcEn && (state_reg != HALTED)),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: each step queues the expected control word
// and halt flag, then compares them against the DUT mid-cycle.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, dREN_me, dWEN_me;
    logic [31:0] instru_de;
    logic        regWr_ex;
    logic [4:0]  regDst_ex;
    logic [1:0]  regSel_ex;
    logic        branchTaken_ex, jump_de, halt_wb;
    logic        pcEn, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, halt;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_unit #(.LOADUSE_BUBBLES(2)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_me(dREN_me), .dWEN_me(dWEN_me), .instru_de(instru_de),
        .regWr_ex(regWr_ex), .regDst_ex(regDst_ex), .regSel_ex(regSel_ex),
        .branchTaken_ex(branchTaken_ex), .jump_de(jump_de), .halt_wb(halt_wb),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .pcEn(pcEn), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
        .flush_fd(flush_fd), .flush_de(flush_de), .halt(halt)
    );

    always #5 CLK = ~CLK;

    // {pcEn, en_fd, en_de, en_em, en_mw, flush_fd, flush_de}
    localparam logic [6:0] FREEZE = 7'b0000000;
    localparam logic [6:0] ALL1   = 7'b1111100;
    localparam logic [6:0] STALL  = 7'b0011101;
    localparam logic [6:0] BRANCH = 7'b1111111;
    localparam logic [6:0] JUMP   = 7'b1111110;
    localparam logic [6:0] IMISS  = 7'b0111110;

    typedef struct {
        string      tag;
        logic [6:0] ctl;
        logic       h;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [6:0] ctl_obs;

    assign ctl_obs = {pcEn, en_fd, en_de, en_em, en_mw, flush_fd, flush_de};

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t);
        return {op, s, t, 16'd0};
    endfunction

    task automatic clear_inputs();
        ihit = 1'b1; dhit = 1'b0; dREN_me = 1'b0; dWEN_me = 1'b0;
        instru_de = 32'd0; regWr_ex = 1'b0; regDst_ex = 5'd0; regSel_ex = 2'b00;
        branchTaken_ex = 1'b0; jump_de = 1'b0; halt_wb = 1'b0;
    endtask

    task automatic load_in_ex(input logic [4:0] dst, input logic [31:0] instr);
        regWr_ex = 1'b1; regSel_ex = REGSEL_LOAD; regDst_ex = dst; instru_de = instr;
    endtask

    task automatic step(input string tag, input logic [6:0] ctl, input logic h);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.h = h;
        sb.push_back(e);
        @(negedge CLK);
        e = sb.pop_front();
        checks++;
        assert (ctl_obs === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl observed=%b expected=%b", e.tag, ctl_obs, e.ctl);
        end
        checks++;
        assert (halt === e.h) else begin
            errors++;
            $error("FAIL %s halt observed=%b expected=%b", e.tag, halt, e.h);
        end
        $display("step %-14s ctl=%b halt=%b", e.tag, ctl_obs, halt);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        clear_inputs();
        nRST = 1'b0;
        step("reset", FREEZE, 1'b0);
        nRST = 1'b1;
        step("idle", ALL1, 1'b0);

        // LW r2 in EX, ADD r3,r2,r1 in ID
        load_in_ex(5'd2, rtype(5'd2, 5'd1, 5'd3));
        step("lu_detect", STALL, 1'b0);
        regWr_ex = 1'b0; regSel_ex = 2'b00; regDst_ex = 5'd0;
        step("lu_bubble2", STALL, 1'b0);
        step("lu_release", ALL1, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (stall_cnt === 32'd2) else begin
            errors++;
            $error("FAIL stall_cnt observed=%0d expected=2", stall_cnt);
        end
`endif
        clear_inputs();
        step("lu_after", ALL1, 1'b0);

        load_in_ex(5'd0, rtype(5'd0, 5'd1, 5'd3));
        step("lu_r0", ALL1, 1'b0);

        load_in_ex(5'd2, rtype(5'd1, 5'd2, 5'd3));
        step("lu_rt", STALL, 1'b0);
        clear_inputs();
        step("lu_rt_b2", STALL, 1'b0);
        step("lu_rt_done", ALL1, 1'b0);

        load_in_ex(5'd2, itype(6'h08, 5'd1, 5'd2));
        step("addi_rt_dst", ALL1, 1'b0);
        load_in_ex(5'd2, rtype(5'd2, 5'd1, 5'd3));
        regSel_ex = 2'b00;
        step("alu_not_load", ALL1, 1'b0);

        clear_inputs();
        dREN_me = 1'b1;
        for (int i = 0; i < 3; i++) step("dmiss", FREEZE, 1'b0);
        dhit = 1'b1;
        step("dhit", ALL1, 1'b0);
        clear_inputs();
        step("dmiss_after", ALL1, 1'b0);

        load_in_ex(5'd2, rtype(5'd2, 5'd1, 5'd3));
        branchTaken_ex = 1'b1;
        step("br_and_lu", BRANCH, 1'b0);
        clear_inputs();
        step("br_no_bubble", ALL1, 1'b0);

        dREN_me = 1'b1; branchTaken_ex = 1'b1;
        step("br_frozen", FREEZE, 1'b0);
        dhit = 1'b1;
        step("br_released", BRANCH, 1'b0);
        clear_inputs();

        load_in_ex(5'd2, rtype(5'd2, 5'd1, 5'd3));
        jump_de = 1'b1;
        step("jmp_lu", STALL, 1'b0);
        regWr_ex = 1'b0; regSel_ex = 2'b00; regDst_ex = 5'd0;
        step("jmp_lu_b2", STALL, 1'b0);
        step("jmp_flush", JUMP, 1'b0);
        clear_inputs();
        step("jmp_after", ALL1, 1'b0);

        load_in_ex(5'd2, rtype(5'd2, 5'd1, 5'd3));
        step("lds_detect", STALL, 1'b0);
        clear_inputs();
        dREN_me = 1'b1;
        step("lds_miss1", FREEZE, 1'b0);
        step("lds_miss2", FREEZE, 1'b0);
        dhit = 1'b1;
        step("lds_resume", STALL, 1'b0);
        clear_inputs();
        step("lds_done", ALL1, 1'b0);

        ihit = 1'b0;
        step("imiss", IMISS, 1'b0);
        clear_inputs();

        load_in_ex(5'd2, rtype(5'd2, 5'd1, 5'd3));
        dREN_me = 1'b1;
        step("mw_lu_frozen", FREEZE, 1'b0);
        dhit = 1'b1;
        step("mw_lu", STALL, 1'b0);
        clear_inputs();
        step("mw_lu_b2", STALL, 1'b0);
        step("mw_lu_done", ALL1, 1'b0);

        halt_wb = 1'b1; dREN_me = 1'b1;
        step("halt_frozen", FREEZE, 1'b0);
        step("halt_held", FREEZE, 1'b0);
        dhit = 1'b1;
        step("halt_accept", ALL1, 1'b0);
        clear_inputs();
        step("halted", FREEZE, 1'b1);
        step("halted2", FREEZE, 1'b1);

        #2 nRST = 1'b0;
        step("reset_halt", FREEZE, 1'b0);
        nRST = 1'b1;
        step("post_reset", ALL1, 1'b0);
        load_in_ex(5'd2, rtype(5'd2, 5'd1, 5'd3));
        step("post_rst_lu", STALL, 1'b0);
        clear_inputs();
        step("post_rst_b2", STALL, 1'b0);
        step("post_rst_run", ALL1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
